// File: rtl/normalize32_seq_pkg.sv
// Shared constants for the sequential 32-bit normalizer: widths, step count,
// FSM encodings and the per-step shift width table.
package normalize32_seq_pkg;

  localparam int DATA_W     = 32;
  localparam int CNT_W      = 6;
  localparam int NORM_STEPS = 5;
  localparam int STEP_W     = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Binary search halves the probed field each step: 16, 8, 4, 2, 1.
  function automatic logic [4:0] stepWidth(input logic [STEP_W-1:0] stage);
    logic [4:0] w;
    case (stage)
      3'd0:    w = 5'd16;
      3'd1:    w = 5'd8;
      3'd2:    w = 5'd4;
      3'd3:    w = 5'd2;
      default: w = 5'd1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/normalize32_seq_if.sv
// Request/result bundle of the normalizer; master drives the request side,
// slave (the normalizer) drives status and result.
interface normalize32_seq_if;
  import normalize32_seq_pkg::*;

  logic              START;
  logic [DATA_W-1:0] D;
  logic              LnR;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] Y;
  logic [CNT_W-1:0]  CNT;
  logic              ZERO;

  modport master (
    output START, D, LnR,
    input  BUSY, DONE, Y, CNT, ZERO
  );

  modport slave (
    input  START, D, LnR,
    output BUSY, DONE, Y, CNT, ZERO
  );

endinterface

// File: rtl/normalize32_seq_step.sv
// One combinational binary-search step: tests the w-bit field at the leading
// (left) or trailing (right) end and shifts it away when it is all zero.
module norm32_step
  import normalize32_seq_pkg::*;
(
  input  logic [DATA_W-1:0] i_acc,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_stage,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_zero,
  output logic [4:0]        o_inc
);

  logic [4:0] w_w;
  logic [5:0] w_rest;

  assign w_w    = stepWidth(i_stage);
  assign w_rest = 6'd32 - {1'b0, w_w};
  assign o_inc  = w_w;

  // Shifting the complementary amount isolates the field under test.
  always_comb begin
    if (i_dir) begin
      o_zero = ((i_acc >> w_rest) == '0);
      o_acc  = o_zero ? (i_acc << w_w) : i_acc;
    end else begin
      o_zero = ((i_acc << w_rest) == '0);
      o_acc  = o_zero ? (i_acc >> w_w) : i_acc;
    end
  end

endmodule

// File: rtl/normalize32_seq.sv
// Sequential normalizer: START/DONE handshake around a five-step binary search
// that yields the leading- or trailing-zero count and the normalized word.
module normalize32_seq
  import normalize32_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  normalize32_seq_if.slave  bus
);

  logic [0:0]        r_state;
  logic [STEP_W-1:0] r_step;
  logic [DATA_W-1:0] r_acc;
  logic              r_dir;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_y;
  logic [CNT_W-1:0]  r_cntOut;
  logic              r_zero;

  logic [DATA_W-1:0] w_accNext;
  logic              w_hit;
  logic [4:0]        w_inc;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_resZero;

  norm32_step u_step (
    .i_acc   (r_acc),
    .i_dir   (r_dir),
    .i_stage (r_step),
    .o_acc   (w_accNext),
    .o_zero  (w_hit),
    .o_inc   (w_inc)
  );

  assign w_cntNext = r_cnt + (w_hit ? {1'b0, w_inc} : 6'd0);
  assign w_resZero = (w_accNext == '0);

  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
  assign bus.Y    = r_y;
  assign bus.CNT  = r_cntOut;
  assign bus.ZERO = r_zero;

  // Result registers change only at commit so consumers see a stable value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_step   <= '0;
      r_acc    <= '0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_y      <= '0;
      r_cntOut <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.START) begin
            r_acc   <= bus.D;
            r_dir   <= bus.LnR;
            r_cnt   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_acc  <= w_accNext;
          r_cnt  <= w_cntNext;
          r_step <= r_step + 3'd1;
          if (r_step == 3'(NORM_STEPS - 1)) begin
            r_zero   <= w_resZero;
            r_cntOut <= w_resZero ? 6'd32 : w_cntNext;
            r_y      <= w_accNext;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_normalize32_seq.sv
// Self-checking bench for normalize32_seq: directed handshake/boundary cases
// plus randomized operands against a bit-scanning reference model.
module tb_normalize32_seq;
  import normalize32_seq_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  normalize32_seq_if bus ();

  normalize32_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vecCount  = 0;
  int missCount = 0;

  logic [31:0] prevY    = '0;
  logic [31:0] prevCnt  = '0;
  logic [31:0] prevZero = '0;
  bit          chainArmed = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  // Reference: scan for the first set bit from the chosen end.
  task automatic refNorm(input logic [31:0] d, input logic lnr,
                         output logic [31:0] y, output logic [31:0] cnt,
                         output logic [31:0] zero);
    int n;
    n = 0;
    if (d == 32'd0) begin
      y = '0; cnt = 32; zero = 1;
    end else begin
      if (lnr) begin
        while (d[31 - n] == 1'b0) n++;
        y = d << n;
      end else begin
        while (d[n] == 1'b0) n++;
        y = d >> n;
      end
      cnt = n; zero = 0;
    end
  endtask

  // One operation; optionally pulses START mid-run and/or arms a request
  // in the DONE cycle for the next call.
  task automatic applyStimulus(input logic [31:0] d, input logic lnr,
                               input bit glitch, input bit armNext,
                               input logic [31:0] nextD, input logic nextLnr);
    logic [31:0] eY, eCnt, eZero;
    int n;
    refNorm(d, lnr, eY, eCnt, eZero);
    if (!chainArmed) begin
      @(negedge CLK);
      bus.START = 1'b1; bus.D = d; bus.LnR = lnr;
    end
    @(negedge CLK);
    bus.START = 1'b0; bus.D = $urandom; bus.LnR = 1'($urandom);
    checkOutput("busyAfterAccept", {31'd0, bus.BUSY}, 32'd1);
    n = 1;
    while (n <= 12) begin
      @(negedge CLK);
      if (bus.DONE) break;
      if (n <= 4) begin
        checkOutput("holdY", bus.Y, prevY);
        checkOutput("holdCnt", {26'd0, bus.CNT}, prevCnt);
      end
      if (glitch && n >= 2) begin
        bus.START = 1'b1; bus.D = $urandom; bus.LnR = 1'($urandom);
      end
      n++;
    end
    checkOutput("latency", n, 5);
    checkOutput("Y", bus.Y, eY);
    checkOutput("CNT", {26'd0, bus.CNT}, eCnt);
    checkOutput("ZERO", {31'd0, bus.ZERO}, eZero);
    checkOutput("busyAtDone", {31'd0, bus.BUSY}, 32'd0);
    prevY = eY; prevCnt = eCnt; prevZero = eZero;
    if (armNext) begin
      bus.START = 1'b1; bus.D = nextD; bus.LnR = nextLnr;
      chainArmed = 1'b1;
    end else begin
      bus.START = 1'b0;
      chainArmed = 1'b0;
    end
  endtask

  task automatic quietCycles(input string tag, input int cycles);
    int dones;
    dones = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (bus.DONE) dones++;
    end
    checkOutput(tag, dones, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rl;
    RST = 1'b0;
    bus.START = 1'b1; bus.D = 32'h1234_5678; bus.LnR = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rstBusy", {31'd0, bus.BUSY}, 32'd0);
    checkOutput("rstDone", {31'd0, bus.DONE}, 32'd0);
    checkOutput("rstY", bus.Y, 32'd0);
    checkOutput("rstCnt", {26'd0, bus.CNT}, 32'd0);
    checkOutput("rstZero", {31'd0, bus.ZERO}, 32'd0);
    bus.START = 1'b0;
    RST = 1'b1;

    applyStimulus(32'h0001_0000, 1'b1, 0, 0, '0, 1'b0);
    applyStimulus(32'h0001_0000, 1'b0, 0, 0, '0, 1'b0);
    applyStimulus(32'h0000_0001, 1'b1, 0, 0, '0, 1'b0);
    applyStimulus(32'h0000_0000, 1'b1, 0, 0, '0, 1'b0);
    applyStimulus(32'h0000_0000, 1'b0, 0, 0, '0, 1'b0);
    applyStimulus(32'h8000_0000, 1'b1, 0, 0, '0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 0, 0, '0, 1'b0);
    applyStimulus(32'h8000_0000, 1'b0, 0, 0, '0, 1'b0);

    applyStimulus(32'h0000_0C00, 1'b1, 1, 0, '0, 1'b0);
    quietCycles("noExtraDone", 8);

    applyStimulus(32'h0040_0000, 1'b0, 0, 1, 32'h0000_0300, 1'b1);
    applyStimulus(32'h0000_0300, 1'b1, 0, 1, 32'h0F00_0000, 1'b0);
    applyStimulus(32'h0F00_0000, 1'b0, 0, 0, '0, 1'b0);

    // Abort a run at step 3 with an asynchronous reset.
    @(negedge CLK);
    bus.START = 1'b1; bus.D = 32'h0000_0010; bus.LnR = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, bus.BUSY}, 32'd0);
    checkOutput("abortDone", {31'd0, bus.DONE}, 32'd0);
    checkOutput("abortY", bus.Y, 32'd0);
    checkOutput("abortCnt", {26'd0, bus.CNT}, 32'd0);
    checkOutput("abortZero", {31'd0, bus.ZERO}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    prevY = '0; prevCnt = '0; prevZero = '0;
    quietCycles("noDoneAfterAbort", 8);

    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      case ($urandom_range(0, 3))
        0: rd = rd >> $urandom_range(0, 31);
        1: rd = rd << $urandom_range(0, 31);
        2: rd = 32'd1 << $urandom_range(0, 31);
        default: ;
      endcase
      rl = 1'($urandom);
      applyStimulus(rd, rl, bit'($urandom_range(0, 3) == 0), 0, '0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/normalize32_seq.md
Name: normalize32_seq

Overview:
Sequential 32-bit normalizer. It is the inverse of the barrel shift: given a data word, it finds the shift amount that brings the first set bit to the boundary.
- LnR=1: count leading zeros and shift left until D[31]=1.
- LnR=0: count trailing zeros and shift right until D[0]=1.
- Algorithm: iterative binary search over 5 cycles (16/8/4/2/1). Uses a START/DONE handshake.
- Placement: sits beside the ALU. Feeds shift-amount and normalized-operand paths, e.g. float normalize and priority logic.

Parameters:
- DATA_W, 32, data width. Only 32 is supported; the 5-step search is fixed to it.
- CNT_W, 6, count width. Must hold 0..32.

Ports:
- CLK    input   1       clock, rising edge
- RST    input   1       reset, asynchronous, active-low
- START  input   1       request. Sampled only when BUSY=0.
- D      input   32      operand. Captured on the accepting edge.
- LnR    input   1       1 = left-normalize (clz), 0 = right-normalize (ctz). Captured with D.
- BUSY   output  1       operation in progress
- DONE   output  1       one-cycle pulse; result committed
- Y      output  32      normalized word
- CNT    output  6       shift amount applied (zero count)
- ZERO   output  1       D was 0

Behaviour:
- Reset (RST=0, asynchronous): BUSY=0, DONE=0, Y=0, CNT=0, ZERO=0, state=IDLE, step=0. Any operation in flight is aborted with no DONE. Release is synchronous to CLK; the first START can be accepted on the first edge after RST=1.
- States:
  - IDLE: BUSY=0. START=1 at edge E0: acc<=D, dir<=LnR, cnt<=0, step<=0, go to RUN, BUSY<=1.
  - RUN: edges E1..E5 perform steps 0..4 with w=16,8,4,2,1.
    - Left: if acc[31:32-w]==0 then acc<=acc<<w and cnt+=w.
    - Right: if acc[w-1:0]==0 then acc<=acc>>w and cnt+=w.
    - Shifts are zero-fill. cnt never exceeds 31 inside RUN.
  - Commit at E5: compute on the step-4 result.
    - ZERO<=(result==0).
    - CNT<= 32 if zero, else the final cnt.
    - Y<= result (0 when zero).
    - DONE<=1, BUSY<=0, back to IDLE.
- Latency: DONE is high in the cycle after E5, i.e. 5 cycles after the accepting edge. DONE is high for exactly one cycle.
- Outputs Y/CNT/ZERO hold the last committed result until the next commit. They do not change at accept or during RUN.
- START while BUSY=1 is ignored, with no queuing. D and LnR changes during RUN have no effect.
- START in the DONE-high cycle is accepted (BUSY=0 then). Back-to-back throughput is one op per 5 cycles.
- Already-normalized input (left: D[31]=1; right: D[0]=1): CNT=0, Y=D. Still takes the full 5 cycles.
- Only the data-path content is fixed per cycle; acc and cnt internals are free but must match the above at commit.

Decomposition:
- Shared definitions (prj_definition.v):
  - state encodings IDLE/RUN
  - NORM_STEPS=5
  - DATA_W, CNT_W
- One sub-module: norm32_step. Combinational.
  - Inputs: acc, dir, stage index.
  - Outputs: next acc, a zero-flag for the tested field, and the increment w.
  - Instantiated once and reused each cycle; the step counter selects w.
- normalize32_seq holds the FSM, step counter, acc/cnt registers and the output registers.

Test Plan:
1. Reset: hold RST=0 with START=1 -> BUSY=0, DONE=0, Y=0, CNT=0, ZERO=0. Assert RST=0 at step 3 of a run -> outputs zero, no DONE pulse.
2. D=32'h0001_0000, LnR=1 -> DONE 5 cycles after accept, Y=32'h8000_0000, CNT=15, ZERO=0.
3. D=32'h0001_0000, LnR=0 -> Y=32'h0000_0001, CNT=16, ZERO=0. Also D=32'h0000_0001, LnR=1 -> Y=32'h8000_0000, CNT=31.
4. D=32'h0000_0000 with either LnR -> Y=0, CNT=32, ZERO=1.
5. Already normalized: D=32'h8000_0000 with LnR=1, and D=32'hFFFF_FFFF with LnR=0 -> CNT=0, Y=D. DONE is still 5 cycles after accept.
6. Handshake:
   - Pulse START again on cycles 2–4 of a run -> ignored, exactly one DONE.
   - START in the DONE cycle -> accepted, second DONE exactly 5 cycles later.
   - Y/CNT hold the first result until then.
